// File: rtl/tdc_pkg.sv
// Shared widths and types for the TDC top-K output stage.
package tdc_pkg;

    localparam int unsigned TDC_TOF_W = 15;
    localparam int unsigned TDC_INT_W = 5;

    // One TOF event at the default widths; "inten" because "int" is a keyword.
    typedef struct packed {
        logic [TDC_TOF_W-1:0] tof;
        logic [TDC_INT_W-1:0] inten;
    } tdc_ev_t;

    typedef enum logic {
        IDLE,
        DRAIN
    } tdc_state_e;

endpackage

// File: rtl/tdc_topk_stream_if.sv
// Readout stream bundle: valid/ready with per-beat event data and frame framing.
interface tdc_topk_stream_if
    import tdc_pkg::*;
#(
    parameter int unsigned TOF_W = TDC_TOF_W,
    parameter int unsigned INT_W = TDC_INT_W,
    parameter int unsigned NUM_W = 2
);
    logic             o_valid;
    logic             o_ready;
    logic [TOF_W-1:0] o_tof;
    logic [INT_W-1:0] o_int;
    logic [NUM_W-1:0] o_num;
    logic             o_last;

    modport master (
        output o_valid,
        output o_tof,
        output o_int,
        output o_num,
        output o_last,
        input  o_ready
    );

    modport slave (
        input  o_valid,
        input  o_tof,
        input  o_int,
        input  o_num,
        input  o_last,
        output o_ready
    );

endinterface

// File: rtl/tdc_topk_sorter.sv
// Per-frame collect table: keeps the DEPTH strongest events sorted by descending
// intensity. The post-insertion table is exported so a frame close can snapshot it
// including an event arriving in the closing cycle.
module tdc_topk_sorter
    import tdc_pkg::*;
#(
    parameter int unsigned TOF_W = TDC_TOF_W,
    parameter int unsigned INT_W = TDC_INT_W,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned NUM_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ev_valid_i,
    input  logic [TOF_W-1:0] ev_tof_i,
    input  logic [INT_W-1:0] ev_int_i,
    input  logic [INT_W-1:0] cfg_min_int_i,
    input  logic             clear_i,
    output logic [TOF_W-1:0] ins_tof_o [DEPTH],
    output logic [INT_W-1:0] ins_int_o [DEPTH],
    output logic [NUM_W-1:0] ins_cnt_o
);

    logic [TOF_W-1:0] tof_q [DEPTH];
    logic [INT_W-1:0] int_q [DEPTH];
    logic [NUM_W-1:0] cnt_q;
    logic [NUM_W-1:0] pos;
    logic             found;
    logic             accept;

    // Insert position: first valid slot strictly weaker than the event (ties stay ahead).
    always_comb begin
        pos   = cnt_q;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && (NUM_W'(i) < cnt_q) && (int_q[i] < ev_int_i)) begin
                pos   = NUM_W'(i);
                found = 1'b1;
            end
        end
    end

    // pos == DEPTH only when the table is full and the event is no stronger than the tail.
    assign accept = ev_valid_i && (ev_int_i >= cfg_min_int_i) && (pos < NUM_W'(DEPTH));

    // Post-insertion table: keep above pos, place the event at pos, shift the rest down.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ins_tof_o[i] = tof_q[i];
            ins_int_o[i] = int_q[i];
        end
        if (accept) begin
            if (pos == '0) begin
                ins_tof_o[0] = ev_tof_i;
                ins_int_o[0] = ev_int_i;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (NUM_W'(i) == pos) begin
                    ins_tof_o[i] = ev_tof_i;
                    ins_int_o[i] = ev_int_i;
                end else if (NUM_W'(i) > pos) begin
                    ins_tof_o[i] = tof_q[i-1];
                    ins_int_o[i] = int_q[i-1];
                end
            end
        end
        ins_cnt_o = (accept && (cnt_q != NUM_W'(DEPTH))) ? cnt_q + NUM_W'(1) : cnt_q;
    end

    // Table state; a clear only zeroes the count, stale slots beyond it are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tof_q[i] <= '0;
                int_q[i] <= '0;
            end
        end else begin
            cnt_q <= clear_i ? '0 : ins_cnt_o;
            for (int i = 0; i < DEPTH; i++) begin
                tof_q[i] <= ins_tof_o[i];
                int_q[i] <= ins_int_o[i];
            end
        end
    end

endmodule

// File: rtl/tdc_topk_stream.sv
// TDC output stage: collects the top-DEPTH events per frame, snapshots them into an
// output bank at frame end and drains the bank strongest-first over a valid/ready stream.
module tdc_topk_stream
    import tdc_pkg::*;
#(
    parameter int unsigned TOF_W = TDC_TOF_W,
    parameter int unsigned INT_W = TDC_INT_W,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned NUM_W = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ev_valid,
    input  logic [TOF_W-1:0]         ev_tof,
    input  logic [INT_W-1:0]         ev_int,
    input  logic                     frame_end,
    input  logic [INT_W-1:0]         cfg_min_int,
    tdc_topk_stream_if.master        strm,
    output logic                     frame_irq,
    output logic                     frame_drop
);

    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [TOF_W-1:0] ins_tof [DEPTH];
    logic [INT_W-1:0] ins_int [DEPTH];
    logic [NUM_W-1:0] ins_cnt;

    tdc_state_e       state_q;
    logic [TOF_W-1:0] bank_tof_q [DEPTH];
    logic [INT_W-1:0] bank_int_q [DEPTH];
    logic [NUM_W-1:0] num_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_nxt;
    logic             nxt_last;
    logic             valid_q;
    logic             last_q;
    logic [TOF_W-1:0] tof_q;
    logic [INT_W-1:0] int_q;
    logic             irq_q;
    logic             drop_q;
    logic             handshake;
    logic             bank_free;
    logic             load;

    tdc_topk_sorter #(
        .TOF_W (TOF_W),
        .INT_W (INT_W),
        .DEPTH (DEPTH),
        .NUM_W (NUM_W)
    ) u_sorter (
        .clk           (clk),
        .rst           (rst),
        .ev_valid_i    (ev_valid),
        .ev_tof_i      (ev_tof),
        .ev_int_i      (ev_int),
        .cfg_min_int_i (cfg_min_int),
        .clear_i       (frame_end),
        .ins_tof_o     (ins_tof),
        .ins_int_o     (ins_int),
        .ins_cnt_o     (ins_cnt)
    );

    // The bank frees up in the very cycle its last beat is accepted.
    assign handshake = valid_q && strm.o_ready;
    assign bank_free = (state_q == IDLE) || (handshake && last_q);
    assign load      = frame_end && bank_free;

    // Next beat index and whether that beat will be the frame's final one.
    always_comb begin
        idx_nxt  = idx_q + IDX_W'(1);
        nxt_last = (NUM_W'(idx_nxt) + NUM_W'(1)) == num_q;
    end

    // Output FSM with bank, registered beat data and one-cycle frame pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            num_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            tof_q   <= '0;
            int_q   <= '0;
            irq_q   <= 1'b0;
            drop_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                bank_tof_q[i] <= '0;
                bank_int_q[i] <= '0;
            end
        end else begin
            irq_q  <= 1'b0;
            drop_q <= 1'b0;
            if (load) begin
                irq_q <= 1'b1;
                num_q <= ins_cnt;
                idx_q <= '0;
                if (ins_cnt != '0) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        bank_tof_q[i] <= ins_tof[i];
                        bank_int_q[i] <= ins_int[i];
                    end
                    state_q <= DRAIN;
                    valid_q <= 1'b1;
                    last_q  <= (ins_cnt == NUM_W'(1));
                    tof_q   <= ins_tof[0];
                    int_q   <= ins_int[0];
                end else begin
                    // Empty frame: announce it but send nothing.
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    last_q  <= 1'b0;
                end
            end else begin
                drop_q <= frame_end;
                if (handshake) begin
                    if (last_q) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                    end else begin
                        idx_q  <= idx_nxt;
                        tof_q  <= bank_tof_q[idx_nxt];
                        int_q  <= bank_int_q[idx_nxt];
                        last_q <= nxt_last;
                    end
                end
            end
        end
    end

    assign strm.o_valid = valid_q;
    assign strm.o_last  = last_q;
    assign strm.o_tof   = tof_q;
    assign strm.o_int   = int_q;
    assign strm.o_num   = num_q;
    assign frame_irq    = irq_q;
    assign frame_drop   = drop_q;

endmodule

// File: doc/tdc_topk_stream.md
Name: tdc_topk_stream

Overview:
- Parametrised successor of the TDC output stage.
- Collects per-frame TOF events and keeps the DEPTH strongest by intensity in a sorted table.
- At frame end, snapshots the table into an output bank and drains it over a valid/ready stream in descending-intensity order, with last-beat marking and a frame interrupt.
- Sits between the TDC capture/TOF arithmetic (already synchronised into clk) and the readout interface.

Parameters:
- TOF_W, 15, TOF code width.
- INT_W, 5, intensity width (0..16 SPADs needs 5).
- DEPTH, 3, events kept per frame; legal range 1..8.
- NUM_W, $clog2(DEPTH+1), derived width of the count field; do not override.

Ports:
- clk  in  1  single logic clock (250 MHz); all ports synchronous to it.
- rst  in  1  asynchronous, active-high reset.
- ev_valid  in  1  one-cycle strobe: event present.
- ev_tof  in  TOF_W  event TOF code.
- ev_int  in  INT_W  event intensity.
- frame_end  in  1  one-cycle strobe: close current frame.
- cfg_min_int  in  INT_W  events with ev_int < cfg_min_int are ignored; sampled quasi-static.
- o_valid  out  1  stream data valid.
- o_ready  in  1  stream data ready.
- o_tof  out  TOF_W  beat TOF.
- o_int  out  INT_W  beat intensity.
- o_num  out  NUM_W  number of events in the frame being drained; constant for the whole drain.
- o_last  out  1  final beat of frame.
- frame_irq  out  1  one-cycle pulse when the output bank is loaded.
- frame_drop  out  1  one-cycle pulse when a frame is discarded because the bank is busy.

Behaviour:
- Reset: collect table empty (count 0), bank empty; o_valid, o_last, frame_irq and frame_drop are 0; o_tof, o_int and o_num are 0.
- Collect table:
  - DEPTH slots, sorted by intensity, descending; a count register ranges 0..DEPTH.
  - An accepted event (ev_valid and ev_int >= cfg_min_int) is inserted at the first slot whose intensity is strictly less than ev_int, or at slot count if no such slot exists. Lower entries shift down one slot.
  - Ties: the older entry stays ahead.
  - When count == DEPTH and ev_int <= slot[DEPTH-1].int, the event is discarded; otherwise the last slot falls off and count saturates at DEPTH.
  - Insertion completes in 1 cycle; back-to-back events every cycle are supported.
- Frame close (frame_end = 1):
  - If ev_valid is also asserted in the same cycle, that event belongs to the closing frame; the snapshot uses the post-insertion table.
  - Bank free: next cycle the bank holds the snapshot, o_num = count, frame_irq pulses, and the collect table clears to count 0.
  - If count == 0, the bank is not loaded and no beats are sent, but frame_irq still pulses with o_num = 0.
  - Bank busy: frame_drop pulses next cycle, the table clears, and the bank is untouched.
  - The bank counts as free in the same cycle the last beat handshakes, so frame_end in that cycle loads the bank.
- Collection continues during drain; new events go to the cleared table.
- Output FSM:
  - States: IDLE, DRAIN.
  - IDLE -> DRAIN on bank load with count > 0. o_valid rises in the same cycle as frame_irq, i.e. 1 cycle after frame_end.
  - In DRAIN, beat index i runs from 0 to o_num-1. o_tof and o_int come from bank slot i. o_last = (i == o_num-1).
  - On o_valid && o_ready: i increments; on the last beat go to IDLE with o_valid low next cycle, unless a bank load happens in the same cycle, in which case re-enter DRAIN at i = 0.
  - o_valid must not drop, and the data must not change, while o_ready is low.
  - In IDLE: o_valid = 0, o_last = 0, data outputs hold their last values.
- Arithmetic: comparisons are unsigned; no TOF arithmetic in this block.
- Reset mid-drain aborts immediately; nothing is replayed.

Decomposition:
- Package tdc_pkg: default widths TDC_TOF_W = 15 and TDC_INT_W = 5, a packed event struct {tof, int}, and the FSM state enum {IDLE, DRAIN}.
- One sub-module, tdc_topk_sorter: the collect table with insertion/shift logic. It exposes the next-state table and count for the snapshot.
- The top level holds the bank, the FSM and the pulses.

Test Plan:
- DEPTH = 3, cfg_min_int = 0; events (tof, int) = (100, 4), (200, 9), (300, 6), (400, 2), then frame_end -> frame_irq; beats (200, 9), (300, 6), (100, 4) with o_num = 3; o_last only on the third beat.
- Ties: events (10, 5), (20, 5), (30, 5), (40, 5), then frame_end -> beats tof 10, 20, 30; event 40 discarded.
- o_ready held low 5 cycles, then toggled every other cycle -> o_valid and data stable while stalled; exactly 3 handshakes; no beat lost or duplicated.
- Second frame_end while 2 beats are still pending -> frame_drop pulse 1 cycle later; the remaining beats of the first frame are unchanged. A frame_end on the last-beat handshake cycle -> the new frame loads, with o_valid continuous across the boundary.
- cfg_min_int = 5; events with int 3, 4 only, then frame_end -> frame_irq, o_num = 0, no o_valid. Same cycle ev_valid (int 7) and frame_end -> event included, o_num = 1.
- rst asserted mid-drain -> all outputs 0 asynchronously; after release the next frame behaves normally.
